// File: rtl/ram_bist_ctrl.sv
// March-style BIST initiator for the single-port synchronous RAM.
// Write/verify a seed pattern, then its inverse; report first failure.
module ram_bist_ctrl #(
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  parameter int ERRW   = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [DWIDTH-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERRW-1:0]   err_count,
  output logic [ASIZE-1:0]  err_addr,
  output logic [DWIDTH-1:0] err_data,
  output logic              ram_ce,
  output logic              ram_wr,
  output logic [ASIZE-1:0]  ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_WR1,
    S_RD1,
    S_FIN,
    S_DONE
  } state_t;

  localparam logic [ASIZE-1:0] LAST = ASIZE'(DEPTH - 1);

  state_t            state;
  state_t            state_d;
  logic [ASIZE-1:0]  a;
  logic [DWIDTH-1:0] pattern_q;
  logic              last;
  logic              wr_ph;
  logic              rd_ph;
  logic              inv_ph;
  logic              accept;
  logic [DWIDTH-1:0] e0;
  logic [DWIDTH-1:0] e_cur;
  logic              cmp_v;
  logic [DWIDTH-1:0] exp_q;
  logic [ASIZE-1:0]  cmp_a;
  logic              mism;
  logic              busy_d;

  assign last   = (a == LAST);
  assign wr_ph  = (state == S_WR0) || (state == S_WR1);
  assign rd_ph  = (state == S_RD0) || (state == S_RD1);
  assign inv_ph = (state == S_WR1) || (state == S_RD1);
  assign accept = (state == S_IDLE) && start;

  assign e0    = pattern_q ^ DWIDTH'(a);
  assign e_cur = inv_ph ? ~e0 : e0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (start) state_d = S_WR0;
      S_WR0:  if (last)  state_d = S_RD0;
      S_RD0:  if (last)  state_d = S_WR1;
      S_WR1:  if (last)  state_d = S_RD1;
      S_RD1:  if (last)  state_d = S_FIN;
      S_FIN:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      a         <= '0;
      pattern_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= (state == S_FIN);
      if (accept) pattern_q <= pattern;
      // Counter restarts at every phase boundary, never wraps in-phase.
      if (state_d != state || !(wr_ph || rd_ph)) begin
        a <= '0;
      end else begin
        a <= a + 1'b1;
      end
    end
  end

  // RAM pins depend only on registered state, counter and pattern_q.
  always_comb begin
    ram_ce   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (1'b1)
      wr_ph: begin
        ram_ce   = 1'b1;
        ram_wr   = 1'b1;
        ram_addr = a;
        ram_din  = e_cur;
      end
      rd_ph: begin
        ram_ce   = 1'b1;
        ram_addr = a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cmp_v <= 1'b0;
      exp_q <= '0;
      cmp_a <= '0;
    end else begin
      cmp_v <= rd_ph;
      if (rd_ph) begin
        exp_q <= e_cur;
        cmp_a <= a;
      end
    end
  end

  assign mism = cmp_v && (ram_dout != exp_q);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_count <= '0;
      err_addr  <= '0;
      err_data  <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      err_addr  <= '0;
      err_data  <= '0;
      pass      <= 1'b0;
    end else begin
      if (mism) begin
        if (err_count == '0) begin
          err_addr <= cmp_a;
          err_data <= ram_dout;
        end
        if (!(&err_count)) err_count <= err_count + 1'b1;
      end
      // The final RD1 compare lands in FIN, so fold it in here.
      if (state == S_FIN) pass <= (err_count == '0) && !mism;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RAM and
// a write scoreboard; a second instance covers counter saturation.
module tb_ram_bist_ctrl;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [15:0] pattern;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [7:0]  err_addr;
  logic [15:0] err_data;
  logic        ram_ce, ram_wr;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic        start_s;
  logic        busy_s, done_s, pass_s;
  logic [1:0]  err_count_s;
  logic [7:0]  err_addr_s;
  logic [15:0] err_data_s;
  logic        ce_s, wr_s;
  logic [7:0]  addr_s;
  logic [15:0] din_s;
  logic [15:0] const_d;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  logic [15:0] mem [0:255];
  logic [15:0] rd_data;
  logic [15:0] q1 = '0;
  logic [15:0] q2 = '0;
  logic [23:0] wq[$];
  logic [23:0] wexp;

  ram_bist_ctrl #(
    .ASIZE(8), .DWIDTH(16), .DEPTH(8), .ERRW(8)
  ) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_addr(err_addr),
    .err_data(err_data),
    .ram_ce(ram_ce), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram_bist_ctrl #(
    .ASIZE(8), .DWIDTH(16), .DEPTH(8), .ERRW(2)
  ) u_sat (
    .clk(clk), .nrst(nrst), .start(start_s), .pattern(pattern),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_count_s), .err_addr(err_addr_s),
    .err_data(err_data_s),
    .ram_ce(ce_s), .ram_wr(wr_s), .ram_addr(addr_s),
    .ram_din(din_s), .ram_dout(const_d)
  );

  assign const_d = 16'h1234;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 1: bit 0 of addr 3 stuck at 0; mode 3: 2-cycle read latency
  always_comb begin
    rd_data = mem[ram_addr];
    if (mode == 1 && ram_addr == 8'd3) rd_data[0] = 1'b0;
  end

  always @(posedge clk) begin
    if (ram_ce && ram_wr) mem[ram_addr] <= ram_din;
    if (ram_ce && !ram_wr) q1 <= rd_data;
    q2 <= q1;
  end

  assign ram_dout = (mode == 3) ? q2 : q1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1 && ram_ce === 1'b1 && ram_wr === 1'b1) begin
      if (wq.size() != 0) wexp = wq.pop_front();
      else wexp = 'x;
      chk("ram_write", {40'h0, ram_addr, ram_din}, {40'h0, wexp});
    end
  end

  task automatic push_writes(input logic [15:0] pat);
    for (int i = 0; i < 8; i++)
      wq.push_back({8'(i), pat ^ 16'(i)});
    for (int i = 0; i < 8; i++)
      wq.push_back({8'(i), ~(pat ^ 16'(i))});
  endtask

  function automatic logic [63:0] outs();
    return {3'b0, busy, done, pass, err_count, err_addr, err_data,
            ram_ce, ram_wr, ram_addr, ram_din};
  endfunction

  task automatic run(input logic [15:0] pat, output int cyc);
    @(negedge clk);
    push_writes(pat);
    pattern = pat;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int n;
  logic ce_seen;

  initial begin
    nrst    = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    pattern = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 64'h0);
    chk("reset_sat", {busy_s, done_s, pass_s, err_count_s, ce_s}, 64'h0);
    nrst = 1'b1;

    // healthy RAM
    run(16'hA5A5, n);
    chk("h_done_cyc", 64'(n), 64'd34);
    chk("h_pass", 64'(pass), 64'd1);
    chk("h_errcnt", 64'(err_count), 64'd0);
    chk("h_busy_done", 64'(busy), 64'd0);
    chk("h_wq_empty", 64'(wq.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("h_pass_hold", {62'h0, pass, done}, 64'b10);

    // stuck-at-0 bit
    mode = 1;
    run(16'h0000, n);
    chk("s_done_cyc", 64'(n), 64'd34);
    chk("s_err_addr", 64'(err_addr), 64'd3);
    chk("s_err_data", 64'(err_data), 64'h0002);
    chk("s_errcnt", 64'(err_count), 64'd1);
    chk("s_pass", 64'(pass), 64'd0);
    mode = 0;

    // saturation with ERRW=2
    @(negedge clk);
    pattern = 16'hA5A5;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 1;
    while (!done_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done_cyc", 64'(n), 64'd34);
    chk("sat_errcnt", 64'(err_count_s), 64'd3);
    chk("sat_err_addr", 64'(err_addr_s), 64'd0);
    chk("sat_err_data", 64'(err_data_s), 64'h1234);
    chk("sat_pass", 64'(pass_s), 64'd0);

    // reset during RD0 addr 2
    @(negedge clk);
    push_writes(16'hA5A5);
    pattern = 16'hA5A5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 11) begin
      @(negedge clk);
      n++;
    end
    chk("r_rd0_a2", {61'h0, ram_ce, ram_wr, 1'b0} | 64'(ram_addr),
        64'b100 | 64'd2);
    nrst = 1'b0;
    wq.delete();
    @(negedge clk);
    chk("r_outs_zero", outs(), 64'h0);
    nrst = 1'b1;
    ce_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ce_seen = ce_seen | ram_ce | busy;
    end
    chk("r_no_access", 64'(ce_seen), 64'd0);
    run(16'hA5A5, n);
    chk("r_rerun_cyc", 64'(n), 64'd34);
    chk("r_rerun_pass", 64'(pass), 64'd1);

    // start pulse mid-run is ignored
    @(negedge clk);
    push_writes(16'h3C3C);
    pattern = 16'h3C3C;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      start = (n == 10);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("m_done_cyc", 64'(n), 64'd34);
    repeat (4) @(negedge clk);
    chk("m_no_rerun", {63'h0, busy | ram_ce}, 64'd0);
    chk("m_wq_empty", 64'(wq.size()), 64'd0);

    // start held high: back-to-back runs
    @(negedge clk);
    push_writes(16'h5A5A);
    pattern = 16'h5A5A;
    start   = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_done1_cyc", 64'(n), 64'd34);
    push_writes(16'h5A5A);
    @(negedge clk);
    chk("b_idle_gap", {62'h0, busy, ram_ce}, 64'd0);
    @(negedge clk);
    chk("b_wr0_start", {61'h0, busy, ram_ce, ram_wr} | 64'(ram_addr),
        64'b111);
    start = 1'b0;
    n = 36;
    while (!done && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk("b_done2_cyc", 64'(n), 64'd69);
    chk("b_pass", 64'(pass), 64'd1);
    chk("b_wq_empty", 64'(wq.size()), 64'd0);

    // RAM with 2-cycle latency must be flagged
    mode = 3;
    run(16'hA5A5, n);
    chk("l_done_cyc", 64'(n), 64'd34);
    chk("l_pass", 64'(pass), 64'd0);
    chk("l_errcnt_nz", 64'(err_count != 8'd0), 64'd1);
    mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
